multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1; 1 means memory states honour mem_ready, 0 means mem_ready is treated as constant 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instr[31:26] from instruction register, sampled in DECODE.
REQ-005 mem_ready  input  1  memory completed current access this cycle.
REQ-006 iord, mem_read, mem_write, ir_write, pc_write, branch  output  1 each  datapath strobes.
REQ-007 regDest, regWrite, memToReg  output  1 each  register-file controls (regDest 1 = rd, 0 = rt).
REQ-008 aluSrcA  output 1; aluSrcB  output 2 (00 B, 01 const 4, 10 sext imm, 11 sext imm<<2); aluOp  output 2 (00 add, 01 sub, 10 funct, 11 unused); pcSrc  output 2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-010 state_dbg  output  4  current state encoding; instr_retired  output  32  completed-instruction count.

Function
REQ-011 States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-012 Outputs are a Moore decode of state; all outputs not listed for a state are 0.
REQ-013 IDLE: all outputs 0; next FETCH unconditionally.
REQ-014 FETCH: mem_read=1, aluSrcB=01; ir_write and pc_write = mem_ready (sole qualified strobes); stay while mem_ready=0, else DECODE.
REQ-015 DECODE: aluSrcB=11; opcode 000000->RTYPEEX, 100011/101011->MEMADR, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, any other->FETCH with illegal_op=1 this cycle.
REQ-016 MEMADR: aluSrcA=1, aluSrcB=10; lw->MEMRD, sw->MEMWR (opcode held stable by IR).
REQ-017 MEMRD: iord=1, mem_read=1; stay until mem_ready, then MEMWB.
REQ-018 MEMWB: regWrite=1, regDest=0, memToReg=1; next FETCH.
REQ-019 MEMWR: iord=1, mem_write=1; stay until mem_ready, then FETCH.
REQ-020 RTYPEEX: aluSrcA=1, aluOp=10; next ALUWB. ALUWB: regWrite=1, regDest=1; next FETCH.
REQ-021 BEQEX: aluSrcA=1, aluOp=01, pcSrc=01, branch=1; next FETCH.
REQ-022 ADDIEX: aluSrcA=1, aluSrcB=10; next ADDIWB. ADDIWB: regWrite=1, regDest=0; next FETCH.
REQ-023 JEX: pcSrc=10, pc_write=1; next FETCH.
REQ-024 regWrite is high for exactly one cycle per lw/R-type/addi; never in any other state.
REQ-025 instr_retired increments by 1 on exit from MEMWB, MEMWR (with mem_ready), ALUWB, BEQEX, ADDIWB, JEX; wraps 0xFFFFFFFF->0; illegal opcodes do not count.
REQ-026 Latency (mem_ready always 1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-027 rst_n low forces state IDLE, all outputs 0, instr_retired 0 immediately, including mid-instruction or mid-stall; no partial write completes.
REQ-028 First FETCH occurs on the second rising edge after rst_n deasserts.

Structure
REQ-029 Opcode constants, state enum, aluSrcB/aluOp/pcSrc encodings belong in shared package mips_pkg.
REQ-030 Single flat module; next-state and output decode in the same module, no sub-modules.

Verification
REQ-031 Reset release, mem_ready=1, opcode 000000 -> states IDLE,FETCH,DECODE,RTYPEEX,ALUWB,FETCH; regWrite=1,regDest=1 only in ALUWB; instr_retired=1.
REQ-032 lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, regWrite=1,memToReg=1 one cycle, total 8 cycles.
REQ-033 Opcode 111111 -> illegal_op pulse in DECODE, return to FETCH, regWrite never high, instr_retired unchanged.
REQ-034 rst_n low during MEMWR stall -> mem_write drops to 0 asynchronously, state IDLE, instr_retired 0.
REQ-035 beq then j back-to-back -> pcSrc=01,branch=1 then pcSrc=10,pc_write=1; 3 cycles each; instr_retired +2.
REQ-036 Force instr_retired 0xFFFFFFFF, retire addi -> count 0x00000000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM state codes,
// datapath mux selects and the DECODE dispatch helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_RTYPEEX = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BEQEX   = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JEX     = 4'd12;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  endfunction

  // Unsupported opcodes fall back to FETCH so the machine keeps running.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     decode_target = S_RTYPEEX;
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_BEQ:       decode_target = S_BEQEX;
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_J:         decode_target = S_JEX;
      default:      decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore decode of datapath strobes from the current
// state, memory stalls on mem_ready, and a retired-instruction counter.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch,
  output logic        regDest,
  output logic        regWrite,
  output logic        memToReg,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic [1:0]  pcSrc,
  output logic        illegal_op,
  output logic [3:0]  state_dbg,
  output logic [31:0] instr_retired
);

  logic [3:0]  state_r;
  logic [3:0]  state_nxt_s;
  logic        run_r;
  logic        mem_rdy_s;
  logic        retire_s;
  logic [31:0] instr_retired_r;

  assign mem_rdy_s     = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state_dbg     = state_r;
  assign instr_retired = instr_retired_r;

  // Next-state logic; IDLE waits one extra edge after reset release via run_r.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:    if (run_r) state_nxt_s = S_FETCH;  else state_nxt_s = S_IDLE;
      S_FETCH:   if (mem_rdy_s) state_nxt_s = S_DECODE; else state_nxt_s = S_FETCH;
      S_DECODE:  state_nxt_s = decode_target(opcode);
      S_MEMADR:  if (opcode == OP_SW) state_nxt_s = S_MEMWR; else state_nxt_s = S_MEMRD;
      S_MEMRD:   if (mem_rdy_s) state_nxt_s = S_MEMWB;  else state_nxt_s = S_MEMRD;
      S_MEMWB:   state_nxt_s = S_FETCH;
      S_MEMWR:   if (mem_rdy_s) state_nxt_s = S_FETCH;  else state_nxt_s = S_MEMWR;
      S_RTYPEEX: state_nxt_s = S_ALUWB;
      S_ALUWB:   state_nxt_s = S_FETCH;
      S_BEQEX:   state_nxt_s = S_FETCH;
      S_ADDIEX:  state_nxt_s = S_ADDIWB;
      S_ADDIWB:  state_nxt_s = S_FETCH;
      S_JEX:     state_nxt_s = S_FETCH;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // Moore output decode; only FETCH strobes and illegal_op look at inputs.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    regDest    = 1'b0;
    regWrite   = 1'b0;
    memToReg   = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = SRCB_B;
    aluOp      = ALUOP_ADD;
    pcSrc      = PCSRC_ALU;
    illegal_op = 1'b0;
    retire_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read = 1'b1;
        aluSrcB  = SRCB_FOUR;
        ir_write = mem_rdy_s;
        pc_write = mem_rdy_s;
      end
      S_DECODE: begin
        aluSrcB    = SRCB_IMM_SH;
        illegal_op = ~op_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        retire_s = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire_s  = mem_rdy_s;
      end
      S_RTYPEEX: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDest  = 1'b1;
        retire_s = 1'b1;
      end
      S_BEQEX: begin
        aluSrcA  = 1'b1;
        aluOp    = ALUOP_SUB;
        pcSrc    = PCSRC_ALUOUT;
        branch   = 1'b1;
        retire_s = 1'b1;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
        retire_s = 1'b1;
      end
      S_JEX: begin
        pcSrc    = PCSRC_JUMP;
        pc_write = 1'b1;
        retire_s = 1'b1;
      end
      default: begin
        retire_s = 1'b0;
      end
    endcase
  end

  // State register and reset-release flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired_r <= 32'd0;
    end else if (retire_s) begin
      instr_retired_r <= instr_retired_r + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: reset, each instruction
// class, memory stalls, illegal opcode, reset during a stall and counter wrap.
module tb_multicycle_control;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        iord, mem_read, mem_write, ir_write, pc_write, branch;
  logic        regDest, regWrite, memToReg, aluSrcA, illegal_op;
  logic [1:0]  aluSrcB, aluOp, pcSrc;
  logic [3:0]  state_dbg;
  logic [31:0] instr_retired;
  logic [16:0] ctl;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  // ctl = {iord,mem_read,mem_write,ir_write,pc_write,branch,regDest,regWrite,memToReg,aluSrcA,aluSrcB,aluOp,pcSrc,illegal_op}
  localparam logic [16:0] C_ZERO   = 17'd0;
  localparam logic [16:0] C_FETCH  = {1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_FSTALL = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_DECODE = {6'b0, 3'b0, 1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_ILLEG  = {6'b0, 3'b0, 1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [16:0] C_MEMADR = {6'b0, 3'b0, 1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEMRD  = {1'b1,1'b1,1'b0,3'b0, 3'b0, 1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEMWB  = {6'b0, 1'b0,1'b1,1'b1, 1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_MEMWR  = {1'b1,1'b0,1'b1,3'b0, 3'b0, 1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_RTYPE  = {6'b0, 3'b0, 1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] C_ALUWB  = {6'b0, 1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_BEQ    = {5'b0,1'b1, 3'b0, 1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] C_ADDIEX = {6'b0, 3'b0, 1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_ADDIWB = {6'b0, 1'b0,1'b1,1'b0, 1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] C_JEX    = {4'b0,1'b1,1'b0, 3'b0, 1'b0,2'b00,2'b00,2'b10,1'b0};

  assign ctl = {iord, mem_read, mem_write, ir_write, pc_write, branch,
                regDest, regWrite, memToReg, aluSrcA, aluSrcB, aluOp, pcSrc, illegal_op};

  multicycle_control #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .regDest(regDest), .regWrite(regWrite),
    .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSrc(pcSrc), .illegal_op(illegal_op), .state_dbg(state_dbg),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_RTYPE;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset_ctl: got %h expected %h", ctl, C_ZERO); end
    checks++; if (instr_retired !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", instr_retired); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL release_edge1: got %0d expected %0d", state_dbg, S_IDLE); end
    @(posedge clk); #1;
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL release_edge2: got %0d expected %0d", state_dbg, S_FETCH); end
    exp_cnt = 32'd0;
  endtask

  task automatic test_rtype();
    logic [3:0]  st [4] = '{S_FETCH, S_DECODE, S_RTYPEEX, S_ALUWB};
    logic [16:0] cv [4] = '{C_FETCH, C_DECODE, C_RTYPE, C_ALUWB};
    int rw = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; opcode = OP_RTYPE; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL rtype_ctl[%0d]: got %h expected %h", i, ctl, cv[i]); end
      if (regWrite) rw++;
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL rtype_end: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (instr_retired !== exp_cnt) begin errors++; $display("FAIL rtype_count: got %0d expected %0d", instr_retired, exp_cnt); end
    checks++; if (rw != 1) begin errors++; $display("FAIL rtype_regwrite_cycles: got %0d expected 1", rw); end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  st [8] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
    logic [16:0] cv [8] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
    logic        mr [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int rw = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; opcode = OP_LW; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL lw_ctl[%0d]: got %h expected %h", i, ctl, cv[i]); end
      if (regWrite) rw++;
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL lw_end: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (instr_retired !== exp_cnt) begin errors++; $display("FAIL lw_count: got %0d expected %0d", instr_retired, exp_cnt); end
    checks++; if (rw != 1) begin errors++; $display("FAIL lw_regwrite_cycles: got %0d expected 1", rw); end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [2] = '{S_FETCH, S_DECODE};
    logic [16:0] cv [2] = '{C_FETCH, C_ILLEG};
    int rw = 0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1; opcode = 6'b111111; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL illegal_ctl[%0d]: got %h expected %h", i, ctl, cv[i]); end
      if (regWrite) rw++;
      @(posedge clk); #1;
    end
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL illegal_end: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_pulse_width: got %b expected 0", illegal_op); end
    checks++; if (instr_retired !== exp_cnt) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", instr_retired, exp_cnt); end
    checks++; if (rw != 0) begin errors++; $display("FAIL illegal_regwrite: got %0d expected 0", rw); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  st [6] = '{S_FETCH, S_DECODE, S_BEQEX, S_FETCH, S_DECODE, S_JEX};
    logic [16:0] cv [6] = '{C_FETCH, C_DECODE, C_BEQ, C_FETCH, C_DECODE, C_JEX};
    logic [5:0]  op [6] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1; opcode = op[i]; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL beqj_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL beqj_ctl[%0d]: got %h expected %h", i, ctl, cv[i]); end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 32'd2;
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL beqj_end: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (instr_retired !== exp_cnt) begin errors++; $display("FAIL beqj_count: got %0d expected %0d", instr_retired, exp_cnt); end
  endtask

  task automatic test_sw_fetch_stall();
    logic [3:0]  st [5] = '{S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
    logic [16:0] cv [5] = '{C_FSTALL, C_FETCH, C_DECODE, C_MEMADR, C_MEMWR};
    logic        mr [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; opcode = OP_SW; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL sw_ctl[%0d]: got %h expected %h", i, ctl, cv[i]); end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL sw_end: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (instr_retired !== exp_cnt) begin errors++; $display("FAIL sw_count: got %0d expected %0d", instr_retired, exp_cnt); end
  endtask

  task automatic test_reset_in_memwr();
    logic [3:0] st [4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
    logic       mr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; opcode = OP_SW; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL swrst_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      @(posedge clk); #1;
    end
    checks++; if (ctl !== C_MEMWR) begin errors++; $display("FAIL swrst_stall_ctl: got %h expected %h", ctl, C_MEMWR); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL swrst_mem_write: got %b expected 0", mem_write); end
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL swrst_state: got %0d expected %0d", state_dbg, S_IDLE); end
    checks++; if (instr_retired !== 32'd0) begin errors++; $display("FAIL swrst_count: got %0d expected 0", instr_retired); end
    exp_cnt = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL swrst_refetch: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (instr_retired !== exp_cnt) begin errors++; $display("FAIL swrst_no_retire: got %0d expected %0d", instr_retired, exp_cnt); end
  endtask

  task automatic test_wrap();
    logic [3:0]  st [4] = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB};
    logic [16:0] cv [4] = '{C_FETCH, C_DECODE, C_ADDIEX, C_ADDIWB};
    force dut.instr_retired_r = 32'hFFFF_FFFF;
    #1;
    release dut.instr_retired_r;
    checks++; if (instr_retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffffffff", instr_retired); end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; opcode = OP_ADDI; #1;
      checks++; if (state_dbg !== st[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      checks++; if (ctl !== cv[i]) begin errors++; $display("FAIL addi_ctl[%0d]: got %h expected %h", i, ctl, cv[i]); end
      @(posedge clk); #1;
    end
    checks++; if (state_dbg !== S_FETCH) begin errors++; $display("FAIL addi_end: got %0d expected %0d", state_dbg, S_FETCH); end
    checks++; if (instr_retired !== 32'h0000_0000) begin errors++; $display("FAIL wrap_count: got %h expected 00000000", instr_retired); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_illegal();
    test_back_to_back();
    test_sw_fetch_stall();
    test_reset_in_memwr();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
